output_drain_buffer: RTL and testbench

Downstream stage of the convolution controller. It captures the output words the datapath presents while `output_valid` is high, tagged with the pixel coordinate and output-group index. It buffers them in a small FIFO and drains them to the external bus through a valid/ready handshake. Because the controller never waits on the bus, the block raises an early stall request so that a whole output group always fits.

---
 rtl/output_drain_buffer.sv | 163 ++++++++++++++++
 tb/tb_output_drain_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/output_drain_buffer.sv
// Output drain FIFO: captures tagged datapath words and drains them over valid/ready.
// Optional group-order checking is built when OUTPUT_DRAIN_SEQCHECK_EN is defined.
module output_drain_buffer #(
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int WORD_WIDTH         = 48,
  parameter int GROUPS             = 6,
  parameter int DEPTH              = 16,
  localparam int XW = $clog2(FEATURE_MAP_WIDTH),
  localparam int YW = $clog2(FEATURE_MAP_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic [XW-1:0]         in_x,
  input  logic [YW-1:0]         in_y,
  input  logic [2:0]            in_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic [XW-1:0]         out_x,
  output logic [YW-1:0]         out_y,
  output logic [2:0]            out_sel,
  output logic                  stall_req,
  output logic                  overflow,
  output logic                  seq_error,
  output logic [13:0]           groups_done,
  output logic                  busy,
  output logic                  done
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WORD_WIDTH + XW + YW + 3;
  localparam logic [AW:0]   FULL_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   STALL_C  = (AW+1)'(DEPTH - GROUPS);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [2:0]    LAST_SEL = 3'(GROUPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [13:0]   groups_q, groups_d;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic          push, pop, drop;

  assign out_valid = (state_q != S_IDLE) && (count_q != '0);
  assign pop       = out_valid && out_ready && !start;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push      = in_valid && !start && (state_q == S_ACTIVE) &&
                     ((count_q != FULL_C) || pop);
  assign drop      = in_valid && !start && (state_q != S_IDLE) && !push;

`ifdef OUTPUT_DRAIN_SEQCHECK_EN
  logic [2:0] exp_sel_q, exp_sel_d;
  logic       seq_err_q, seq_err_d;

  always_comb begin
    exp_sel_d = exp_sel_q;
    seq_err_d = seq_err_q;
    if (start) begin
      exp_sel_d = '0;
      seq_err_d = 1'b0;
    end else if (push) begin
      if (in_sel != exp_sel_q) seq_err_d = 1'b1;
      exp_sel_d = (in_sel == LAST_SEL) ? 3'd0 : in_sel + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      exp_sel_q <= '0;
      seq_err_q <= 1'b0;
    end else begin
      exp_sel_q <= exp_sel_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_error = seq_err_q;
`else
  assign seq_error = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    groups_d   = groups_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    if (start) begin
      state_d    = S_ACTIVE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      groups_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (in_sel == LAST_SEL) groups_d = groups_q + 14'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (drop) overflow_d = 1'b1;
      case (state_q)
        S_ACTIVE: if (flush) state_d = S_ACTIVE == S_ACTIVE ? S_FLUSH : S_FLUSH;
        // Leave as soon as the last word is popped so done lines up with that pop.
        S_FLUSH: if (count_d == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      groups_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      groups_q   <= groups_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_data, in_x, in_y, in_sel};
  end

  assign {out_data, out_x, out_y, out_sel} = mem_q[rd_ptr_q];
  assign stall_req   = count_q > STALL_C;
  assign overflow    = overflow_q;
  assign groups_done = groups_q;
  assign busy        = state_q != S_IDLE;
  assign done        = done_q;

endmodule

// File: tb/tb_output_drain_buffer.sv
// Directed plus randomized bench for output_drain_buffer against a queue-based model.
module tb_output_drain_buffer;

  logic        clk = 1'b0;
  logic        arst_n_in, start, flush, in_valid, out_ready;
  logic [47:0] in_data;
  logic [6:0]  in_x, in_y;
  logic [2:0]  in_sel;
  logic        out_valid, stall_req, overflow, seq_error, busy, done;
  logic [47:0] out_data;
  logic [6:0]  out_x, out_y;
  logic [2:0]  out_sel;
  logic [13:0] groups_done;

  output_drain_buffer dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_x(in_x), .in_y(in_y), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .out_sel(out_sel), .stall_req(stall_req),
    .overflow(overflow), .seq_error(seq_error), .groups_done(groups_done),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] d;
    logic [6:0]  x;
    logic [6:0]  y;
    logic [2:0]  s;
  } ent_t;

  ent_t        mq[$];
  int          m_state;  // 0 idle, 1 active, 2 flush
  logic        m_ovf, m_seq, m_done;
  logic [13:0] m_groups;
  int          m_exp;
  int          n_pass = 0, n_total = 0;
  int          sel_ctr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    logic ev;
    ev = (m_state != 0) && (mq.size() > 0);
    chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
    chk("stall_req", {63'd0, stall_req}, {63'd0, mq.size() > 10});
    chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
    chk("seq_error", {63'd0, seq_error}, {63'd0, m_seq});
    chk("groups_done", {50'd0, groups_done}, {50'd0, m_groups});
    chk("busy", {63'd0, busy}, {63'd0, m_state != 0});
    chk("done", {63'd0, done}, {63'd0, m_done});
    if (ev) begin
      chk("out_data", {16'd0, out_data}, {16'd0, mq[0].d});
      chk("out_tags", {47'd0, out_x, out_y, out_sel}, {47'd0, mq[0].x, mq[0].y, mq[0].s});
    end
  endtask

  task automatic cyc(input logic v, input logic [2:0] s, input logic [6:0] x,
                     input logic [6:0] y, input logic rdy, input logic st,
                     input logic fl, input logic rn);
    logic [47:0] d;
    logic        can_pop, accept;
    ent_t        e;
    d = {16'($urandom), 32'($urandom)};
    in_valid = v; in_sel = s; in_x = x; in_y = y; in_data = d;
    out_ready = rdy; start = st; flush = fl; arst_n_in = rn;
    @(posedge clk);
    if (!rn) begin
      m_state = 0; mq.delete(); m_ovf = 0; m_seq = 0; m_groups = 0; m_done = 0; m_exp = 0;
    end else if (st) begin
      m_state = 1; mq.delete(); m_ovf = 0; m_seq = 0; m_groups = 0; m_done = 0; m_exp = 0;
    end else begin
      m_done  = 0;
      can_pop = (m_state != 0) && (mq.size() > 0) && rdy;
      accept  = v && (m_state == 1) && (mq.size() < 16 || can_pop);
      if (v && m_state != 0 && !accept) m_ovf = 1;
      if (can_pop) void'(mq.pop_front());
      if (accept) begin
        e.d = d; e.x = x; e.y = y; e.s = s;
        mq.push_back(e);
        if (s == 3'd5) m_groups = m_groups + 14'd1;
`ifdef OUTPUT_DRAIN_SEQCHECK_EN
        if (int'(s) != m_exp) m_seq = 1;
        m_exp = (s == 3'd5) ? 0 : int'(s) + 1;
`endif
      end
      if (m_state == 1 && fl) m_state = 2;
      else if (m_state == 2 && mq.size() == 0) begin
        m_state = 0;
        m_done  = 1;
      end
    end
    #1;
    check_all();
  endtask

  task automatic push_seq(input logic rdy);
    cyc(1'b1, 3'(sel_ctr), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
        rdy, 1'b0, 1'b0, 1'b1);
    sel_ctr = (sel_ctr + 1) % 6;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 3'd0, 7'd0, 7'd0, rdy, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_start();
    cyc(1'b0, 3'd0, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    sel_ctr = 0;
  endtask

  initial begin
    logic [47:0] head;
    int          ndone;
    logic        lv;
    m_state = 0; m_ovf = 0; m_seq = 0; m_done = 0; m_groups = 0; m_exp = 0;

    // Reset
    cyc(1'b0, 3'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Single group through the FIFO
    do_start();
    for (int i = 0; i < 6; i++) cyc(1'b1, 3'(i), 7'd4, 7'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("single_groups", {50'd0, groups_done}, 64'd1);

    // Backpressure up to full, then push+pop at full, then overflow
    for (int i = 0; i < 16; i++) begin
      push_seq(1'b0);
      if (i == 0) head = out_data;
      if (i == 9) chk("stall_after10", {63'd0, stall_req}, 64'd0);
      if (i == 10) chk("stall_after11", {63'd0, stall_req}, 64'd1);
    end
    chk("head_stable", {16'd0, out_data}, {16'd0, head});
    for (int i = 0; i < 4; i++) begin
      push_seq(1'b1);
      chk("full_pushpop_ovf", {63'd0, overflow}, 64'd0);
      chk("full_pushpop_stall", {63'd0, stall_req}, 64'd1);
    end
    head = out_data;
    push_seq(1'b0);
    chk("overflow_17th", {63'd0, overflow}, 64'd1);
    chk("head_stable_ovf", {16'd0, out_data}, {16'd0, head});
    for (int i = 0; i < 18; i++) idle(1'b1);

    // Flush with alternating ready
    do_start();
    for (int i = 0; i < 5; i++) push_seq(1'b0);
    cyc(1'b0, 3'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(i == 1, 3'd0, 7'd1, 7'd1, (i % 2) == 0, 1'b0, 1'b0, 1'b1);
      if (done) ndone++;
    end
    chk("flush_done_count", ndone, 64'd1);
    chk("flush_ovf", {63'd0, overflow}, 64'd1);
    chk("flush_busy", {63'd0, busy}, 64'd0);

    // Group order check
    do_start();
    cyc(1'b1, 3'd0, 7'd2, 7'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 3'd1, 7'd2, 7'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 3'd3, 7'd2, 7'd3, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef OUTPUT_DRAIN_SEQCHECK_EN
    chk("seq_err_set", {63'd0, seq_error}, 64'd1);
`else
    chk("seq_err_tied", {63'd0, seq_error}, 64'd0);
`endif
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Randomized traffic
    do_start();
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [2:0] s;
      r = $urandom_range(0, 99);
      if (r < 2) do_start();
      else if (r < 4) cyc(1'b0, 3'd0, 7'd0, 7'd0, $urandom_range(0, 1), 1'b0, 1'b1, 1'b1);
      else begin
        lv = ($urandom_range(0, 3) != 0);
        s  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 5)) : 3'(sel_ctr);
        cyc(lv, s, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
            $urandom_range(0, 2) != 0, 1'b0, 1'b0, 1'b1);
        if (lv) sel_ctr = (int'(s) + 1) % 6;
      end
    end

    // Reset in the middle of an operation
    do_start();
    for (int i = 0; i < 7; i++) push_seq(1'b0);
    cyc(1'b0, 3'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_groups", {50'd0, groups_done}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
